// File: rtl/unsigned_multiplier_seq_if.sv
// Operand/result bundle for the sequential multiply-accumulate unit.
// The master drives the request and operands; the slave returns status and product.
interface unsigned_multiplier_seq_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     addend;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, multiplicand, multiplier, addend,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier, addend,
        output busy, done, product
    );
endinterface

// File: rtl/unsigned_multiplier_seq.sv
// Shift-add multiply-accumulate: product = multiplicand * multiplier + addend,
// one fixed-latency result (WIDTH+1 cycles) per accepted start.
module unsigned_multiplier_seq #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    unsigned_multiplier_seq_if.slave  bus,
    output logic [1:0]                dbg_state_o
);

    // Handshake: start is accepted on a rising edge only while busy=0 (IDLE or
    // DONE); busy is high for the WIDTH RUN cycles that follow, then done pulses
    // for exactly one cycle with product valid. product holds until the next
    // result is written; start while busy is dropped, never queued.

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [2*WIDTH-1:0]   partial;

    // A is widened before shifting so the top partial product keeps every bit.
    assign partial = {{WIDTH{1'b0}}, a_q} << cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    a_d     = bus.multiplicand;
                    b_d     = bus.multiplier;
                    acc_d   = {{WIDTH{1'b0}}, bus.addend};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (b_q[0]) begin
                    acc_d = acc_q + partial;
                end
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                // Final iteration: publish the completed sum, never a partial one.
                if (cnt_q == LAST_CNT) begin
                    product_d = acc_d;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q == ST_RUN);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.product = product_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_unsigned_multiplier_seq.sv
// Directed and random checks of the sequential multiply-accumulate unit
// against a plain-arithmetic reference model.
module tb_unsigned_multiplier_seq;
    localparam int W   = 8;
    localparam int LAT = W + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_cmp = 0;
    int         n_mis = 0;
    logic [2*W-1:0] exp_q[$];

    unsigned_multiplier_seq_if #(.WIDTH(W)) bus ();

    unsigned_multiplier_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no end of run, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mac(input int unsigned a, input int unsigned b,
                                               input int unsigned c);
        return (2*W)'(a * b + c);
    endfunction

    task automatic issue(input int unsigned a, input int unsigned b, input int unsigned c);
        bus.start        = 1'b1;
        bus.multiplicand = W'(a);
        bus.multiplier   = W'(b);
        bus.addend       = W'(c);
        exp_q.push_back(ref_mac(a, b, c));
    endtask

    task automatic scramble();
        bus.multiplicand = W'($urandom);
        bus.multiplier   = W'($urandom);
        bus.addend       = W'($urandom);
    endtask

    // Counts falling edges until done is seen, with a bounded wait.
    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            chk({tag, "_excl"}, 32'(bus.busy & bus.done), 32'd0);
        end while (!bus.done && cycles < 4 * LAT);
        chk({tag, "_timeout"}, 32'(bus.done), 32'd1);
    endtask

    task automatic check_product(input string tag);
        logic [2*W-1:0] e;
        chk({tag, "_sbq"}, 32'(exp_q.size()), 32'd1);
        e = exp_q.pop_front();
        chk({tag, "_prod"}, 32'(bus.product), 32'(e));
    endtask

    task automatic single_op(input int unsigned a, input int unsigned b, input int unsigned c,
                             input string tag, input bit mid_start);
        int cyc;
        int total;
        logic [2*W-1:0] held;
        @(negedge clk);
        issue(a, b, c);
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
        total = 1;
        chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
        chk({tag, "_done1"}, 32'(bus.done), 32'd0);
        if (mid_start) begin
            repeat (2) @(negedge clk);
            bus.start = 1'b1;
            scramble();
            @(negedge clk);
            bus.start = 1'b0;
            total += 3;
        end
        wait_done(tag, cyc);
        total += cyc;
        chk({tag, "_lat"}, 32'(total), 32'(LAT));
        chk({tag, "_busyd"}, 32'(bus.busy), 32'd0);
        check_product(tag);
        held = bus.product;
        @(negedge clk);
        chk({tag, "_donew"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_hold"}, 32'(bus.product), 32'(held));
    endtask

    initial begin
        int cyc;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.addend       = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_prod", 32'(bus.product), 32'd0);
        rst = 1'b0;

        single_op(5, 20, 0, "t1", 1'b0);
        single_op(3, 5, 0, "t2a", 1'b0);
        single_op(4, 2, 1, "t2b", 1'b0);
        single_op(255, 255, 255, "t3max", 1'b0);
        single_op(0, 77, 7, "t3zero", 1'b0);
        single_op(200, 0, 0, "t3allz", 1'b0);
        single_op(9, 11, 3, "t4mid", 1'b1);

        // Back-to-back with start held high through DONE.
        @(negedge clk);
        issue(17, 6, 2);
        for (int i = 0; i < 4; i++) begin
            wait_done("t5", cyc);
            chk("t5_period", 32'(cyc), 32'(LAT));
            check_product("t5");
            if (i < 3) issue(12 + i, 13 * (i + 1), i + 1);
            else bus.start = 1'b0;
        end
        @(negedge clk);
        chk("t5_end_done", 32'(bus.done), 32'd0);
        chk("t5_end_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of RUN.
        @(negedge clk);
        issue(100, 150, 50);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_busy_pre", 32'(bus.busy), 32'd1);
        rst       = 1'b1;
        bus.start = 1'b1;
        #1;
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_done", 32'(bus.done), 32'd0);
        chk("t6_prod", 32'(bus.product), 32'd0);
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        chk("t6_busy_rst", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        rst       = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            chk("t6_nodone", 32'(bus.done | bus.busy), 32'd0);
        end
        single_op(123, 45, 6, "t6_next", 1'b0);

        for (int i = 0; i < 1000; i++) begin
            single_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                      "rnd", (i % 50) == 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
